calcu_mailbox_sequencer: RTL

- Calculator-side master for the calculator port of the 16-word data memory.
- On a `go` request it does the following in order:
  - writes operand A, operand B and a sentinel into the mailbox words;
  - writes the command word;
  - polls result word 6 until the CPU overwrites the sentinel, or until a timeout expires;
  - clears the command word and returns the result.
- Sits between the calculator front end (keypad/display logic) and the data memory's `EntradaCalcu`/`addressCalcu`/`writeEnableCalcu`/`resultadoCalcu` port.

---
 rtl/calcu_mailbox_pkg.sv | 37 +++
 rtl/calcu_timeout_counter.sv | 36 +++
 rtl/calcu_mailbox_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/calcu_mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calcu_mailbox_pkg
// Description : Shared state encoding, mailbox word map and command helper
//               for the calculator-side mailbox sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package calcu_mailbox_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_A    = 3'd1,
        WR_B    = 3'd2,
        WR_SENT = 3'd3,
        WR_CMD  = 3'd4,
        WAIT    = 3'd5,
        CLR_CMD = 3'd6,
        DONE    = 3'd7
    } state_t;

    localparam logic [3:0] ADDR_A   = 4'd0;
    localparam logic [3:0] ADDR_B   = 4'd1;
    localparam logic [3:0] ADDR_CMD = 4'd2;
    localparam logic [3:0] ADDR_RES = 4'd6;

    localparam int CMD_VALID_BIT = 31;

    function automatic logic [31:0] cmd_word(input logic [3:0] op);
        logic [31:0] w;
        w                = 32'd0;
        w[CMD_VALID_BIT] = 1'b1;
        w[3:0]           = op;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calcu_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : calcu_timeout_counter
// Description : Up-counter with synchronous clear/enable and a terminal-count
//               flag at TIMEOUT_CYCLES-1.
// Revision    : 1.0 - initial release
// ============================================================================
module calcu_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int TO_W           = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clear,
    input  logic            i_enable,
    output logic [TO_W-1:0] o_count,
    output logic            o_terminal
);

    logic [TO_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TO_W'(1);
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == TO_W'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/calcu_mailbox_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : calcu_mailbox_sequencer
// Description : Calculator-side master that posts operands and a command to
//               the data-memory mailbox, polls for the result, and times out.
// Revision    : 1.0 - initial release
// ============================================================================
module calcu_mailbox_sequencer
    import calcu_mailbox_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1_000_000,
    parameter int          TO_W           = 20,
    parameter logic [31:0] SENTINEL       = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [3:0]  opcode,
    output logic [31:0] calc_addr,
    output logic [31:0] calc_wdata,
    output logic        calc_we,
    input  logic [31:0] calc_rdata,
    output logic        busy,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        timeout
);

    state_t          r_state;
    logic [31:0]     r_b;
    logic [3:0]      r_op;
    logic [31:0]     r_rdata_q;
    logic [31:0]     r_result;
    logic            r_ok;
    logic [3:0]      r_addr;
    logic [31:0]     r_wdata;
    logic            r_we;
    logic            r_busy;
    logic            r_result_valid;
    logic            r_timeout;

    logic [TO_W-1:0] w_count;
    logic            w_tc;
    logic            w_cnt_clr;
    logic            w_cnt_en;
    logic            w_armed;

    assign w_cnt_clr = (r_state == WR_CMD);
    assign w_cnt_en  = (r_state == WAIT);
    // The first two poll samples may predate the sentinel write; ignore them.
    assign w_armed   = (w_count >= TO_W'(2));

    calcu_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_cnt_clr),
        .i_enable   (w_cnt_en),
        .o_count    (w_count),
        .o_terminal (w_tc)
    );

    // Outputs are registered, so each branch loads the values for the state
    // being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_b            <= '0;
            r_op           <= '0;
            r_rdata_q      <= SENTINEL;
            r_result       <= '0;
            r_ok           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_we           <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_we           <= 1'b0;
            r_wdata        <= '0;
            r_result_valid <= 1'b0;
            r_timeout      <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_addr <= '0;
                    r_busy <= 1'b0;
                    if (go) begin
                        // Operand A goes straight into the write-data register.
                        r_b     <= operand_b;
                        r_op    <= opcode;
                        r_state <= WR_A;
                        r_busy  <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= ADDR_A;
                        r_wdata <= operand_a;
                    end
                end
                WR_A: begin
                    r_state <= WR_B;
                    r_we    <= 1'b1;
                    r_addr  <= ADDR_B;
                    r_wdata <= r_b;
                end
                WR_B: begin
                    r_state <= WR_SENT;
                    r_we    <= 1'b1;
                    r_addr  <= ADDR_RES;
                    r_wdata <= SENTINEL;
                end
                WR_SENT: begin
                    r_state <= WR_CMD;
                    r_we    <= 1'b1;
                    r_addr  <= ADDR_CMD;
                    r_wdata <= cmd_word(r_op);
                end
                WR_CMD: begin
                    r_state <= WAIT;
                    r_addr  <= ADDR_RES;
                end
                WAIT: begin
                    r_rdata_q <= calc_rdata;
                    if (w_armed && (r_rdata_q != SENTINEL)) begin
                        r_result <= r_rdata_q;
                        r_ok     <= 1'b1;
                        r_state  <= CLR_CMD;
                        r_we     <= 1'b1;
                        r_addr   <= ADDR_CMD;
                    end else if (w_tc) begin
                        r_result <= SENTINEL;
                        r_ok     <= 1'b0;
                        r_state  <= CLR_CMD;
                        r_we     <= 1'b1;
                        r_addr   <= ADDR_CMD;
                    end
                end
                CLR_CMD: begin
                    r_state        <= DONE;
                    r_addr         <= '0;
                    r_result_valid <= r_ok;
                    r_timeout      <= ~r_ok;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_addr  <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_addr  <= '0;
                end
            endcase
        end
    end

    assign calc_addr    = {28'd0, r_addr};
    assign calc_wdata   = r_wdata;
    assign calc_we      = r_we;
    assign busy         = r_busy;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign timeout      = r_timeout;

endmodule
`default_nettype wire
